// File: rtl/ksa_pkg.sv
// rtl/ksa_pkg.sv - shared types and width helpers for the ubksa_pipe Kogge-Stone adder
package ksa_pkg;

    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

    function automatic int ksa_w(input int xw, input int yw);
        return (xw > yw) ? xw : yw;
    endfunction

    function automatic int ksa_l(input int w);
        return (w <= 1) ? 0 : $clog2(w);
    endfunction

endpackage

// File: rtl/ubksa_pipe_if.sv
// rtl/ubksa_pipe_if.sv - operand/sum handshake bundle for ubksa_pipe (cin present under KSA_CIN_EN)
interface ubksa_pipe_if #(
    parameter int XW = 8,
    parameter int YW = 12
);
    import ksa_pkg::*;

    localparam int W = ksa_w(XW, YW);

    logic          in_valid;
    logic          in_ready;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
`ifdef KSA_CIN_EN
    logic          cin;
`endif
    logic          out_valid;
    logic          out_ready;
    logic [W:0]    s;

`ifdef KSA_CIN_EN
    modport master (output in_valid, x, y, cin, out_ready, input in_ready, out_valid, s);
    modport slave  (input in_valid, x, y, cin, out_ready, output in_ready, out_valid, s);
`else
    modport master (output in_valid, x, y, out_ready, input in_ready, out_valid, s);
    modport slave  (input in_valid, x, y, out_ready, output in_ready, out_valid, s);
`endif

endinterface

// File: rtl/ksa_prefix_cell.sv
// rtl/ksa_prefix_cell.sv - (G,P) prefix combine: hi absorbs the lower-order group lo
module ksa_prefix_cell
    import ksa_pkg::*;
(
    input  gp_t hi,
    input  gp_t lo,
    output gp_t o
);

    assign o.g = hi.g | (hi.p & lo.g);
    assign o.p = hi.p & lo.p;

endmodule

// File: rtl/ubksa_pipe.sv
// rtl/ubksa_pipe.sv - pipelined Kogge-Stone adder, one stage per prefix level; KSA_CIN_EN adds carry-in
module ubksa_pipe
    import ksa_pkg::*;
#(
    parameter int XW = 8,
    parameter int YW = 12
) (
    input  logic         clk,
    input  logic         rst,
    ubksa_pipe_if.slave  bus
);

    localparam int W = ksa_w(XW, YW);
    localparam int L = ksa_l(W);

    logic         adv;
    logic [W-1:0] xe, ye;
    logic [W-1:0] nxt_g [0:L];
    logic [W-1:0] nxt_p [0:L];
    logic [W-1:0] g_d [0:L];
    logic [W-1:0] g_q [0:L];
    logic [W-1:0] p_d [0:L];
    logic [W-1:0] p_q [0:L];
    logic [W-1:0] p0_d [0:L];
    logic [W-1:0] p0_q [0:L];
    logic [L:0]   vld_d, vld_q;
    logic [W:0]   c;
    logic [W:0]   s_d, s_q;
    logic         out_vld_d, out_vld_q;
    logic         cin_last;

    assign adv           = !out_vld_q | bus.out_ready;
    // Reset empties the pipe, so it can always take operands while rst is high.
    assign bus.in_ready  = adv | rst;
    assign bus.out_valid = out_vld_q;
    assign bus.s         = s_q;

    assign xe       = W'(bus.x);
    assign ye       = W'(bus.y);
    assign nxt_g[0] = xe & ye;
    assign nxt_p[0] = xe ^ ye;

    for (genvar k = 0; k < L; k++) begin : g_lvl
        for (genvar i = 0; i < W; i++) begin : g_bit
            if (i >= (1 << k)) begin : g_cell
                gp_t hi, lo, o;
                assign hi = {g_q[k][i], p_q[k][i]};
                assign lo = {g_q[k][i-(1<<k)], p_q[k][i-(1<<k)]};
                ksa_prefix_cell u_cell (.hi(hi), .lo(lo), .o(o));
                assign nxt_g[k+1][i] = o.g;
                assign nxt_p[k+1][i] = o.p;
            end else begin : g_pass
                assign nxt_g[k+1][i] = g_q[k][i];
                assign nxt_p[k+1][i] = p_q[k][i];
            end
        end
    end

`ifdef KSA_CIN_EN
    logic [L:0] cin_d, cin_q;

    always_comb begin
        cin_d = cin_q;
        if (adv) begin
            cin_d[0] = bus.cin;
            for (int k = 1; k <= L; k++) cin_d[k] = cin_q[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) cin_q <= '0;
        else     cin_q <= cin_d;
    end

    assign cin_last = cin_q[L];
`else
    assign cin_last = 1'b0;
`endif

    always_comb begin
        g_d   = g_q;
        p_d   = p_q;
        p0_d  = p0_q;
        vld_d = vld_q;
        if (adv) begin
            g_d[0]   = nxt_g[0];
            p_d[0]   = nxt_p[0];
            p0_d[0]  = nxt_p[0];
            vld_d[0] = bus.in_valid;
            for (int k = 1; k <= L; k++) begin
                g_d[k]   = nxt_g[k];
                p_d[k]   = nxt_p[k];
                p0_d[k]  = p0_q[k-1];
                vld_d[k] = vld_q[k-1];
            end
        end
    end

    // After the last level, (G,P)[i] spans bits i..0, so each carry needs only cin.
    always_comb begin
        c[0] = cin_last;
        for (int i = 0; i < W; i++) c[i+1] = g_q[L][i] | (p_q[L][i] & cin_last);
        s_d       = s_q;
        out_vld_d = out_vld_q;
        if (adv) begin
            s_d       = {c[W], p0_q[L] ^ c[W-1:0]};
            out_vld_d = vld_q[L];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k <= L; k++) begin
                g_q[k]  <= '0;
                p_q[k]  <= '0;
                p0_q[k] <= '0;
            end
            vld_q     <= '0;
            s_q       <= '0;
            out_vld_q <= 1'b0;
        end else begin
            g_q       <= g_d;
            p_q       <= p_d;
            p0_q      <= p0_d;
            vld_q     <= vld_d;
            s_q       <= s_d;
            out_vld_q <= out_vld_d;
        end
    end

endmodule

// File: tb/tb_ubksa_pipe.sv
// tb/tb_ubksa_pipe.sv - directed bench for ubksa_pipe (default and 1-bit instances)
module tb_ubksa_pipe;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ubksa_pipe_if #(.XW(8), .YW(12)) bus ();
    ubksa_pipe_if #(.XW(1), .YW(1))  bus1 ();

    ubksa_pipe #(.XW(8), .YW(12)) dut  (.clk(clk), .rst(rst), .bus(bus));
    ubksa_pipe #(.XW(1), .YW(1))  dut1 (.clk(clk), .rst(rst), .bus(bus1));

    typedef struct {
        logic [7:0]  x;
        logic [11:0] y;
        logic        cin;
        logic [12:0] exp;
    } vec_t;

    vec_t        vecs[$];
    logic [12:0] sb[$];
    int          out_cyc[$];
    int          n_chk = 0, n_fail = 0, cyc = 0, n_in = 0, n_out = 0;
    logic [12:0] last_s = '0;
    logic        stalled = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drive(input logic iv, input logic [7:0] xx, input logic [11:0] yy, input logic ordy);
        bus.in_valid  = iv;
        bus.x         = xx;
        bus.y         = yy;
        bus.out_ready = ordy;
`ifdef KSA_CIN_EN
        bus.cin       = 1'b0;
`endif
        #1;
        if (stalled) begin
            check("stall_hold_valid", 32'(bus.out_valid), 32'd1);
            check("stall_hold_s", 32'(bus.s), 32'(last_s));
        end
        if (!ordy && bus.out_valid) check("stall_in_ready", 32'(bus.in_ready), 32'd0);
        if (bus.out_valid && ordy) begin
            n_out++;
            out_cyc.push_back(cyc);
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_output: got %0h expected no output (cycle %0d)", bus.s, cyc);
            end else begin
                check("result", 32'(bus.s), 32'(sb.pop_front()));
            end
        end
        stalled = bus.out_valid && !ordy;
        last_s  = bus.s;
        if (iv && bus.in_ready) begin
            sb.push_back(13'(xx) + 13'(yy));
            n_in++;
        end
        tick();
    endtask

    task automatic run_vec(input vec_t v);
        int lat;
        bus.in_valid  = 1'b1;
        bus.x         = v.x;
        bus.y         = v.y;
        bus.out_ready = 1'b1;
`ifdef KSA_CIN_EN
        bus.cin       = v.cin;
`endif
        #1;
        check("vec_in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check("vec_latency", 32'(lat), 32'd6);
        check("vec_sum", 32'(bus.s), 32'(v.exp));
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs.push_back('{8'hFF, 12'hFFF, 1'b0, 13'h10FE});
        vecs.push_back('{8'h00, 12'h000, 1'b0, 13'h0000});
        vecs.push_back('{8'h01, 12'hFFF, 1'b0, 13'h1000});
        vecs.push_back('{8'h80, 12'h080, 1'b0, 13'h0100});
        vecs.push_back('{8'hFF, 12'h000, 1'b0, 13'h00FF});
        vecs.push_back('{8'h00, 12'hFFF, 1'b0, 13'h0FFF});
        vecs.push_back('{8'hAA, 12'h555, 1'b0, 13'h05FF});
        vecs.push_back('{8'h55, 12'h0AA, 1'b0, 13'h00FF});
        vecs.push_back('{8'h12, 12'h345, 1'b0, 13'h0357});
        vecs.push_back('{8'hFF, 12'hF01, 1'b0, 13'h1000});
`ifdef KSA_CIN_EN
        vecs.push_back('{8'h00, 12'hFFF, 1'b1, 13'h1000});
        vecs.push_back('{8'hFF, 12'hFFF, 1'b1, 13'h10FF});
`endif

        rst            = 1'b1;
        bus.in_valid   = 1'b1;
        bus.x          = 8'hFF;
        bus.y          = 12'hFFF;
        bus.out_ready  = 1'b0;
        bus1.in_valid  = 1'b1;
        bus1.x         = 1'b1;
        bus1.y         = 1'b1;
        bus1.out_ready = 1'b1;
`ifdef KSA_CIN_EN
        bus.cin        = 1'b0;
        bus1.cin       = 1'b0;
`endif
        repeat (3) tick();
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_s", 32'(bus.s), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst1_out_valid", 32'(bus1.out_valid), 32'd0);
        check("rst1_s", 32'(bus1.s), 32'd0);
        rst           = 1'b0;
        bus1.in_valid = 1'b0;

        foreach (vecs[i]) run_vec(vecs[i]);

        // 1-bit operands: every combination, latency 2
        for (int i = 0; i < 4; i++) begin
            logic [1:0] exp1 [4];
            int lat;
            exp1 = '{2'd0, 2'd1, 2'd1, 2'd2};
            bus1.x        = 1'(i >> 1);
            bus1.y        = 1'(i);
            bus1.in_valid = 1'b1;
            tick();
            bus1.in_valid = 1'b0;
            lat = 1;
            while (!bus1.out_valid && lat < 20) begin
                tick();
                lat++;
            end
            check("w1_latency", 32'(lat), 32'd2);
            check("w1_sum", 32'(bus1.s), 32'(exp1[i]));
            tick();
        end

        // back-to-back inputs emerge on consecutive cycles
        out_cyc.delete();
        drive(1'b1, 8'h00, 12'h000, 1'b1);
        drive(1'b1, 8'h01, 12'hFFF, 1'b1);
        drive(1'b1, 8'h80, 12'h080, 1'b1);
        repeat (10) drive(1'b0, 8'h00, 12'h000, 1'b1);
        check("b2b_count", 32'(out_cyc.size()), 32'd3);
        if (out_cyc.size() == 3) begin
            check("b2b_gap0", 32'(out_cyc[1] - out_cyc[0]), 32'd1);
            check("b2b_gap1", 32'(out_cyc[2] - out_cyc[1]), 32'd1);
        end
        check("b2b_drained", 32'(sb.size()), 32'd0);

        // full pipe, consumer stalls 4 cycles, then drain
        n_in  = 0;
        n_out = 0;
        for (int i = 0; i < 8; i++) drive(1'b1, 8'(i * 37), 12'(i * 101 + 7), 1'b1);
        for (int i = 0; i < 4; i++) drive(1'b1, 8'hC3, 12'h3C5, 1'b0);
        repeat (12) drive(1'b0, 8'h00, 12'h000, 1'b1);
        check("stall_inputs_taken", 32'(n_in), 32'd8);
        check("stall_outputs", 32'(n_out), 32'd8);
        check("stall_drained", 32'(sb.size()), 32'd0);

        // reset with three operands in flight
        drive(1'b1, 8'h11, 12'h022, 1'b1);
        drive(1'b1, 8'h33, 12'h044, 1'b1);
        drive(1'b1, 8'h55, 12'h066, 1'b1);
        drive(1'b0, 8'h00, 12'h000, 1'b1);
        check("midrst_no_out_a", 32'(bus.out_valid), 32'd0);
        drive(1'b0, 8'h00, 12'h000, 1'b1);
        check("midrst_no_out_b", 32'(bus.out_valid), 32'd0);
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        bus.x        = 8'hFF;
        bus.y        = 12'hFFF;
        tick();
        check("midrst_no_out_c", 32'(bus.out_valid), 32'd0);
        tick();
        check("midrst_no_out_d", 32'(bus.out_valid), 32'd0);
        check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        rst = 1'b0;
        sb.delete();
        stalled = 1'b0;
        n_in    = 0;
        n_out   = 0;
        drive(1'b1, 8'h03, 12'h004, 1'b1);
        repeat (10) drive(1'b0, 8'h00, 12'h000, 1'b1);
        check("postrst_inputs", 32'(n_in), 32'd1);
        check("postrst_outputs", 32'(n_out), 32'd1);
        check("postrst_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
